// File: rtl/reg_lock_tracker.sv
// Scoreboard of pending register writes: one saturating counter per architectural
// register, raised by the launcher and lowered by any number of writeback ports.
package maverickOne_pkg;
  localparam int NUM_REGS        = 32;
  localparam int NUM_OUTSTANDING = 4;
endpackage

module reg_lock_tracker #(
  parameter int NUM_REGS        = maverickOne_pkg::NUM_REGS,
  parameter int NUM_OUTSTANDING = maverickOne_pkg::NUM_OUTSTANDING,
  parameter int NUM_WB          = 2,
  localparam int RW             = $clog2(NUM_REGS),
  localparam int CW             = $clog2(NUM_OUTSTANDING + 1)
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic                         clear_i,
  input  logic                         lock_valid_i,
  input  logic [RW-1:0]                lock_rd_i,
  output logic                         lock_ready_o,
  input  logic [NUM_WB-1:0]            unlock_valid_i,
  input  logic [NUM_WB-1:0][RW-1:0]    unlock_rd_i,
  output logic [NUM_REGS-1:0]          locks_o,
  output logic                         busy_o,
  output logic                         underflow_o
);

  // Lock handshake: a lock is taken on a rising edge where lock_valid_i and
  // lock_ready_o are both high; ready never depends on valid. Unlocks have no
  // handshake and are always consumed on the edge where their strobe is high.

  localparam int DW = $clog2(NUM_WB + 1);
  localparam int SW = ((CW > DW) ? CW : DW) + 1;

  logic [CW-1:0]       count_q [NUM_REGS];
  logic [CW-1:0]       count_d [NUM_REGS];
  logic [SW-1:0]       up_w    [NUM_REGS];
  logic [SW-1:0]       dn_w    [NUM_REGS];
  logic [NUM_REGS-1:0] locks_q, locks_d;
  logic                busy_q;
  logic                underflow_q, underflow_d;
  logic                lock_fire;
  logic                uf_any;

  assign lock_ready_o = !srst_i && !clear_i &&
                        (count_q[lock_rd_i] < CW'(NUM_OUTSTANDING));
  assign lock_fire    = lock_valid_i && lock_ready_o;

  // Per-register increment (0/1) and decrement (number of matching ports).
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      up_w[r] = {{(SW-CW){1'b0}}, count_q[r]};
      if (lock_fire && (lock_rd_i == RW'(r))) begin
        up_w[r] = up_w[r] + SW'(1);
      end
      dn_w[r] = '0;
      for (int p = 0; p < NUM_WB; p++) begin
        if (unlock_valid_i[p] && (unlock_rd_i[p] == RW'(r))) begin
          dn_w[r] = dn_w[r] + SW'(1);
        end
      end
    end
  end

  always_comb begin
    uf_any  = 1'b0;
    locks_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      count_d[r] = '0;
      if (clear_i || (r == 0)) begin
        count_d[r] = '0;
      end else if (dn_w[r] > up_w[r]) begin
        count_d[r] = '0;
        uf_any     = 1'b1;
      end else begin
        count_d[r] = CW'(up_w[r] - dn_w[r]);
      end
      locks_d[r] = (count_d[r] != '0);
    end
    underflow_d = underflow_q || uf_any;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        count_q[r] <= '0;
      end
      locks_q     <= '0;
      busy_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        count_q[r] <= count_d[r];
      end
      locks_q     <= locks_d;
      busy_q      <= |locks_d;
      underflow_q <= underflow_d;
    end
  end

  assign locks_o     = locks_q;
  assign busy_o      = busy_q;
  assign underflow_o = underflow_q;

endmodule
